// File: rtl/mfp_als_spi_sampler_pkg.sv
// mfp_als_spi_sampler_pkg: shared constants, FSM state encoding and frame
// field helper for the PmodALS SPI sampler.
package mfp_als_spi_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_QUIET = 3'd3,
        ST_DONE  = 3'd4
    } als_state_t;

    localparam int ALS_FRAME_BITS        = 16;
    localparam int ALS_DATA_MSB          = 12;
    localparam int ALS_DATA_LSB          = 5;
    localparam int ALS_CLK_DIV_DEF       = 16;
    localparam int ALS_SAMPLE_PERIOD_DEF = 500000;

    // The ADC frame carries 3 leading zeros, 8 data bits, then trailing zeros.
    function automatic logic [7:0] als_extract(
        input logic [ALS_FRAME_BITS-1:0] frame
    );
        return frame[ALS_DATA_MSB:ALS_DATA_LSB];
    endfunction

endpackage

// File: rtl/mfp_spi_half_period_timer.sv
// mfp_spi_half_period_timer: counts CLK_DIV cycles and pulses o_tick on the
// last one. Ports: i_clk, i_rst (sync, high), i_restart (zero the count), o_tick.
module mfp_spi_half_period_timer #(
    parameter int CLK_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/mfp_als_spi_sampler.sv
// mfp_als_spi_sampler: periodic / on-demand SPI reader for the PmodALS light
// sensor. Ports: SI_ClkIn, SI_Reset (sync, high), enable, start, SPI_CS,
// SPI_SCK, SPI_SDO, sample, sample_valid, busy, overrun, sample_count.
module mfp_als_spi_sampler
    import mfp_als_spi_sampler_pkg::*;
#(
    parameter int CLK_DIV       = ALS_CLK_DIV_DEF,
    parameter int SAMPLE_PERIOD = ALS_SAMPLE_PERIOD_DEF
) (
    input  logic        SI_ClkIn,
    input  logic        SI_Reset,
    input  logic        enable,
    input  logic        start,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    input  logic        SPI_SDO,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] sample_count
);

    localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(SAMPLE_PERIOD - 1);
    localparam logic [3:0] LAST_BIT = 4'(ALS_FRAME_BITS - 1);

    als_state_t r_state;
    als_state_t w_state_nxt;

    logic                      w_tick;
    logic                      w_restart;
    logic                      w_busy;
    logic                      w_expire;
    logic                      w_request;
    logic [PW-1:0]             r_period;
    logic                      r_pending;
    logic                      r_overrun;
    logic                      r_phase;
    logic [3:0]                r_bit;
    logic [ALS_FRAME_BITS-1:0] r_shift;
    logic                      r_cs;
    logic                      r_sck;
    logic [7:0]                r_sample;
    logic                      r_valid;
    logic [15:0]               r_count;

    // Start and expiry in the same cycle merge into a single request.
    assign w_expire  = enable && (r_period == '0);
    assign w_request = start || w_expire;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_request || r_pending) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick && r_phase && (r_bit == LAST_BIT)) begin
                    w_state_nxt = ST_QUIET;
                end
            end
            ST_QUIET: begin
                if (w_tick) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every state entry starts a fresh half-period; within SHIFT the timer
    // wraps on its own to pace the SCK halves.
    assign w_restart = (w_state_nxt != r_state);

    mfp_spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .i_clk     (SI_ClkIn),
        .i_rst     (SI_Reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_state   <= ST_IDLE;
            r_period  <= PERIOD_RELOAD;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_phase   <= 1'b0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b1;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (enable) begin
                r_period <= (r_period == '0) ? PERIOD_RELOAD
                                             : r_period - 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_request) begin
                r_pending <= 1'b1;
            end
            if (w_request && r_pending) begin
                r_overrun <= 1'b1;
            end

            // r_phase: 0 = low half, 1 = high half of the current SCK period.
            if (r_state == ST_SETUP) begin
                r_phase <= 1'b0;
                r_bit   <= '0;
            end else if ((r_state == ST_SHIFT) && w_tick) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + 1'b1;
                end
            end

            // Capture on the edge where the registered SCK goes low->high.
            if ((r_state == ST_SHIFT) && r_phase && !r_sck) begin
                r_shift <= {r_shift[ALS_FRAME_BITS-2:0], SPI_SDO};
            end

            r_cs  <= !((r_state == ST_SETUP) || (r_state == ST_SHIFT));
            r_sck <= (r_state == ST_SHIFT) ? r_phase : 1'b1;

            r_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_sample <= als_extract(r_shift);
                r_count  <= r_count + 1'b1;
            end
        end
    end

    assign SPI_CS       = r_cs;
    assign SPI_SCK      = r_sck;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = w_busy;
    assign overrun      = r_overrun;
    assign sample_count = r_count;

endmodule

// File: tb/tb_mfp_als_spi_sampler.sv
// tb_mfp_als_spi_sampler: randomized self-checking bench with a behavioural
// PmodALS sensor and a timing/result reference model.
module tb_mfp_als_spi_sampler;

    localparam int CD   = 2;
    localparam int SP   = 200;
    localparam int CONV = 34 * CD + 1;
    localparam int LAT  = 2 + 34 * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        sdo = 1'b0;
    logic        cs;
    logic        sck;
    logic [7:0]  sample;
    logic        valid;
    logic        busy;
    logic        overrun;
    logic [15:0] count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    mfp_als_spi_sampler #(
        .CLK_DIV       (CD),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .SI_ClkIn     (clk),
        .SI_Reset     (rst),
        .enable       (enable),
        .start        (start),
        .SPI_CS       (cs),
        .SPI_SCK      (sck),
        .SPI_SDO      (sdo),
        .sample       (sample),
        .sample_valid (valid),
        .busy         (busy),
        .overrun      (overrun),
        .sample_count (count)
    );

    always @(posedge clk) cyc++;

    // Sensor: a new bit appears on every falling SCK edge, MSB first.
    logic [15:0] cur_frame = 16'h0B60;
    int bit_idx = 0;

    always @(negedge cs) begin
        bit_idx = 0;
        sdo = 1'b0;
    end

    always @(negedge sck) begin
        if (cs === 1'b0 && bit_idx < 16) begin
            sdo = cur_frame[15 - bit_idx];
            bit_idx++;
        end
    end

    // Bus monitor, sampled on the falling clock edge.
    int cs_low = 0;
    int sck_rises = 0;
    int sck_falls = 0;
    int valids = 0;
    int cs_falls[$];
    logic prev_cs = 1'b1;
    logic prev_sck = 1'b1;

    always @(negedge clk) begin
        if (cs === 1'b0) cs_low++;
        if (cs === 1'b0 && prev_sck === 1'b0 && sck === 1'b1) sck_rises++;
        if (cs === 1'b0 && prev_sck === 1'b1 && sck === 1'b0) sck_falls++;
        if (valid === 1'b1) valids++;
        if (prev_cs === 1'b1 && cs === 1'b0) cs_falls.push_back(cyc);
        prev_cs = cs;
        prev_sck = sck;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        cs_low = 0;
        sck_rises = 0;
        sck_falls = 0;
        valids = 0;
        cs_falls.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_count = 0;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        vectors++;
        if (at < 0) begin
            miscompares++;
            $display("FAIL valid_timeout: no sample_valid within %0d cycles",
                     budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({cs, sck} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_spi: got cs,sck=%b%b want 11", cs, sck);
        end
        vectors++;
        if ({valid, busy, overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got v,b,o=%b%b%b want 000",
                     valid, busy, overrun);
        end
        vectors++;
        if (sample !== 8'h00 || count !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: got sample=%h count=%h want 00 0000",
                     sample, count);
        end
        rst = 1'b0;
        model_count = 0;
        tick(2);
    endtask

    task automatic test_single();
        int c0;
        int at;
        clr_mon();
        cur_frame = 16'h0B60;
        c0 = cyc;
        pulse_start();
        model_count++;
        wait_valid(200, at);
        vectors++;
        if (at - c0 != LAT) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want %0d", at - c0, LAT);
        end
        vectors++;
        if (sample !== 8'h5B) begin
            miscompares++;
            $display("FAIL single_sample: got %h want 5b", sample);
        end
        vectors++;
        if (count !== 16'(model_count)) begin
            miscompares++;
            $display("FAIL single_count: got %0d want %0d", count, model_count);
        end
        tick(10);
        vectors++;
        if (cs_low != 33 * CD) begin
            miscompares++;
            $display("FAIL single_cs_low: got %0d want %0d", cs_low, 33 * CD);
        end
        vectors++;
        if (sck_rises != 16) begin
            miscompares++;
            $display("FAIL single_sck_rises: got %0d want 16", sck_rises);
        end
        vectors++;
        if (valids != 1) begin
            miscompares++;
            $display("FAIL single_valids: got %0d want 1", valids);
        end
        vectors++;
        if (cs_falls.size() != 1 || cs_falls[0] - c0 != 2) begin
            miscompares++;
            $display("FAIL single_cs_fall: got n=%0d want cs fall at +2",
                     cs_falls.size());
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_random_frames();
        int at;
        logic [7:0] exp_s;
        for (int n = 0; n < 6; n++) begin
            cur_frame = 16'($urandom);
            exp_s = 8'((cur_frame >> 5) & 16'h00FF);
            clr_mon();
            tick($urandom_range(1, 20));
            pulse_start();
            model_count++;
            wait_valid(200, at);
            tick(4);
            vectors++;
            if (sample !== exp_s) begin
                miscompares++;
                $display("FAIL rand_sample[%0d]: frame=%h got %h want %h",
                         n, cur_frame, sample, exp_s);
            end
            vectors++;
            if (count !== 16'(model_count) || valids != 1 || sck_rises != 16) begin
                miscompares++;
                $display("FAIL rand_frame[%0d]: count=%0d/%0d v=%0d r=%0d",
                         n, count, model_count, valids, sck_rises);
            end
        end
    endtask

    task automatic test_back_to_back();
        int at1;
        int at2;
        do_reset();
        clr_mon();
        cur_frame = 16'($urandom);
        pulse_start();
        tick(10);
        pulse_start();
        tick(5);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_overrun: got %b want 0", overrun);
        end
        pulse_start();
        tick(1);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overrun: got %b want 1", overrun);
        end
        wait_valid(CONV + 10, at1);
        tick(5);
        vectors++;
        if (cs_falls.size() != 2 || cs_falls[1] != at1 + 2) begin
            miscompares++;
            $display("FAIL b2b_pending_start: falls=%0d want 2 at valid+2",
                     cs_falls.size());
        end
        wait_valid(CONV + 10, at2);
        tick(300);
        vectors++;
        if (count !== 16'd2 || valids != 2 || cs_falls.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_runs: count=%0d valids=%0d falls=%0d want 2",
                     count, valids, cs_falls.size());
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overrun_sticky: got %b want 1", overrun);
        end
        do_reset();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_overrun_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_periodic();
        int e;
        do_reset();
        clr_mon();
        e = cyc;
        enable = 1'b1;
        tick(1000);
        enable = 1'b0;
        tick(200);
        vectors++;
        if (valids != 5 || count !== 16'd5) begin
            miscompares++;
            $display("FAIL periodic_count: valids=%0d count=%0d want 5",
                     valids, count);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_overrun: got %b want 0", overrun);
        end
        vectors++;
        if (cs_falls.size() != 5 || cs_falls[0] - e != SP + 1) begin
            miscompares++;
            $display("FAIL periodic_first: falls=%0d want first at +%0d",
                     cs_falls.size(), SP + 1);
        end
        for (int k = 1; k < cs_falls.size(); k++) begin
            vectors++;
            if (cs_falls[k] - cs_falls[k-1] != SP) begin
                miscompares++;
                $display("FAIL periodic_spacing[%0d]: got %0d want %0d",
                         k, cs_falls[k] - cs_falls[k-1], SP);
            end
        end
    endtask

    task automatic test_start_and_expiry();
        int e;
        do_reset();
        clr_mon();
        e = cyc;
        enable = 1'b1;
        tick(SP - 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        enable = 1'b0;
        tick(250);
        vectors++;
        if (valids != 1 || cs_falls.size() != 1) begin
            miscompares++;
            $display("FAIL merge_once: valids=%0d falls=%0d want 1 1",
                     valids, cs_falls.size());
        end
        vectors++;
        if (cs_falls.size() == 1 && cs_falls[0] - e != SP + 1) begin
            miscompares++;
            $display("FAIL merge_time: got +%0d want +%0d",
                     cs_falls[0] - e, SP + 1);
        end
        vectors++;
        if (overrun !== 1'b0 || count !== 16'd1) begin
            miscompares++;
            $display("FAIL merge_state: overrun=%b count=%0d want 0 1",
                     overrun, count);
        end
    endtask

    task automatic test_abort();
        bit hit;
        do_reset();
        clr_mon();
        cur_frame = 16'($urandom);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (sck_falls >= 7) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL abort_reach: 7th SCK period not seen, falls=%0d",
                     sck_falls);
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({cs, sck, busy, valid} !== 4'b1100) begin
            miscompares++;
            $display("FAIL abort_outputs: got cs,sck,busy,v=%b%b%b%b want 1100",
                     cs, sck, busy, valid);
        end
        rst = 1'b0;
        tick(150);
        vectors++;
        if (valids != 0 || sample !== 8'h00 || count !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_result: valids=%0d sample=%h count=%0d want 0",
                     valids, sample, count);
        end
        vectors++;
        if (cs_falls.size() != 1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: falls=%0d overrun=%b want 1 0",
                     cs_falls.size(), overrun);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_random_frames();
        test_back_to_back();
        test_periodic();
        test_start_and_expiry();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
